// File: rtl/multi_range_pkg.sv
// Shared types, default sizes and the range-bound test for multi_range.
package multi_range_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT     = 32;
    localparam int REP_WIDTH_DEFAULT = 4;

    // Comparison width for the bound test; callers sign-extend their
    // operands into it, which covers any WIDTH up to 64 (including the
    // WIDTH+1 bit sum).
    localparam int CMP_W = 66;

    // True while i is still strictly before the exclusive bound in the
    // direction of travel.
    function automatic logic in_range(
        input logic signed [CMP_W-1:0] i,
        input logic signed [CMP_W-1:0] limit,
        input logic                    step_neg
    );
        return step_neg ? (i > limit) : (i < limit);
    endfunction

endpackage

// File: rtl/rep_counter.sv
// Repeat-index counter: counts 0..reps_eff-1 and flags the last repeat.
// A reps value of 0 behaves as 1, so the counter then sits at 0 with tc set.
module rep_counter
    import multi_range_pkg::*;
#(
    parameter int REP_WIDTH = REP_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 en,
    input  logic [REP_WIDTH-1:0] reps,
    output logic [REP_WIDTH-1:0] count,
    output logic                 tc
);

    logic [REP_WIDTH-1:0] last_idx;

    // Highest repeat index for the latched repeat count.
    always_comb begin
        last_idx = '0;
        if (reps != '0) begin
            last_idx = reps - 1'b1;
        end
        tc = (count == last_idx);
    end

    // Clear wins over enable; on the last repeat the index wraps to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            if (tc) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_range.sv
// Range generator: streams range(base, limit, step), each value repeated
// reps times, over a ready/valid output with start/done control.
module multi_range
    import multi_range_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int REP_WIDTH = REP_WIDTH_DEFAULT
) (
    input  logic                        _clock,
    input  logic                        _reset,
    input  logic                        _start,
    input  logic                        _ready,
    input  logic signed [WIDTH-1:0]     base,
    input  logic signed [WIDTH-1:0]     limit,
    input  logic signed [WIDTH-1:0]     step,
    input  logic        [REP_WIDTH-1:0] reps,
    output logic                        _valid,
    output logic                        _done,
    output logic signed [WIDTH-1:0]     _0,
    output logic        [REP_WIDTH-1:0] _1
);

    state_t                      state;
    logic signed [WIDTH-1:0]     i_q;
    logic signed [WIDTH-1:0]     limit_q;
    logic signed [WIDTH-1:0]     step_q;
    logic        [REP_WIDTH-1:0] reps_q;

    logic        [REP_WIDTH-1:0] r;
    logic                        tc;

    logic signed [WIDTH:0]       sum;
    logic signed [CMP_W-1:0]     sum_ext;
    logic signed [CMP_W-1:0]     limit_q_ext;
    logic signed [CMP_W-1:0]     base_ext;
    logic signed [CMP_W-1:0]     limit_ext;
    logic                        ovf;
    logic                        next_ok;
    logic                        start_empty;
    logic                        hs;
    logic                        last;

    // Next-value adder, overflow detect and bound tests for both the
    // running range and the arguments presented with _start.
    always_comb begin
        sum         = {i_q[WIDTH-1], i_q} + {step_q[WIDTH-1], step_q};
        ovf         = sum[WIDTH] ^ sum[WIDTH-1];
        sum_ext     = {{(CMP_W-WIDTH-1){sum[WIDTH]}}, sum};
        limit_q_ext = {{(CMP_W-WIDTH){limit_q[WIDTH-1]}}, limit_q};
        base_ext    = {{(CMP_W-WIDTH){base[WIDTH-1]}}, base};
        limit_ext   = {{(CMP_W-WIDTH){limit[WIDTH-1]}}, limit};

        // An overflowed sum never counts as in range, so a wrapped value
        // can never be emitted.
        next_ok     = !ovf && in_range(sum_ext, limit_q_ext, step_q[WIDTH-1]);
        start_empty = (step == '0) || !in_range(base_ext, limit_ext, step[WIDTH-1]);

        hs          = (state == RUN) && _ready;
        // Final handshake: last repeat of the last in-range value.
        last        = tc && !next_ok;
    end

    // Repeat index; held on the final handshake so _1 keeps the last
    // emitted index while DONE.
    rep_counter #(
        .REP_WIDTH (REP_WIDTH)
    ) u_rep_counter (
        .clk   (_clock),
        .rst_n (_reset),
        .clear (_start),
        .en    (hs && !last),
        .reps  (reps_q),
        .count (r),
        .tc    (tc)
    );

    // Control FSM: _start restarts from any state, including mid-run.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state <= IDLE;
        end else if (_start) begin
            state <= start_empty ? DONE : RUN;
        end else if (hs && last) begin
            state <= DONE;
        end
    end

    // Argument registers and current value; the value only advances when
    // the next one is in range, so _0 holds the last emission in DONE.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            i_q     <= '0;
            limit_q <= '0;
            step_q  <= '0;
            reps_q  <= '0;
        end else if (_start) begin
            i_q     <= base;
            limit_q <= limit;
            step_q  <= step;
            reps_q  <= reps;
        end else if (hs && tc && next_ok) begin
            i_q     <= sum[WIDTH-1:0];
        end
    end

    assign _valid = (state == RUN);
    assign _done  = (state == DONE);
    assign _0     = i_q;
    assign _1     = r;

endmodule
